alu_mc_ctrl: RTL and testbench
==============================

# alu_mc_ctrl

Issue-side controller for the ALU's multi-cycle bit-manipulation path (BEXT, BDEP). It sits between the issue stage and the `alu`, and passes single-cycle operations straight through. For multi-cycle operations it captures and holds the operands stable for the whole operation, back-pressures issue, and collects the completion pulse (`multi_cycle_o` / `multi_cycle_result_o`). It then writes back exactly one result per accepted instruction, tagged with its transaction ID, with flush abort and a timeout guard.

## Interface
Parameters:
- `MaxCycles`, 72: cycles allowed in BUSY before timeout; must be ≥ 2.
- `CntWidth`, `$clog2(MaxCycles+1)`: width of the busy-cycle counter.

Ports:
- `clk_i` in 1: clock, single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush; abandons any in-flight operation.
- `fu_data_i` in `fu_data_t`: issued operation (operator, operands, trans_id).
- `alu_valid_i` in 1: `fu_data_i` is valid this cycle.
- `alu_ready_o` out 1: controller can accept an issue this cycle.
- `fu_data_o` out `fu_data_t`: operation driven into `alu.fu_data_i`.
- `alu_result_i` in 64: `alu.result_o`.
- `mc_done_i` in 1: `alu.multi_cycle_o`; one-cycle completion pulse.
- `mc_result_i` in 64: `alu.multi_cycle_result_o`; valid when `mc_done_i` = 1.
- `alu_valid_o` out 1: writeback valid.
- `alu_result_o` out 64: writeback data.
- `alu_trans_id_o` out `TRANS_ID_BITS`: writeback tag.
- `timeout_o` out 1: one-cycle pulse when a multi-cycle op times out.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States: IDLE, BUSY, ABORT.
- **IDLE**
  - `alu_ready_o` = 1 and `fu_data_o` = `fu_data_i` (combinational pass-through).
  - `alu_valid_i` & ~`flush_i` & operator ∉ {BEXT, BDEP}: `alu_valid_o` = 1 in the same cycle, with `alu_result_o` = `alu_result_i` and `alu_trans_id_o` = `fu_data_i.trans_id`. State stays IDLE.
  - `alu_valid_i` & ~`flush_i` & operator ∈ {BEXT, BDEP}: capture `fu_data_i` into the hold register, clear the counter, go BUSY. No writeback this cycle.
  - `flush_i` in IDLE: the issue is ignored and no writeback occurs.
- **BUSY**
  - `alu_ready_o` = 0 and `fu_data_o` = hold register. The counter increments every cycle.
  - `flush_i` has priority over done and timeout: no writeback, go ABORT.
  - `mc_done_i`: `alu_valid_o` = 1, `alu_result_o` = `mc_result_i`, `alu_trans_id_o` = held trans_id, go IDLE. Ready stays 0 in this cycle, so at most one writeback occurs per cycle.
  - Counter = `MaxCycles`-1 with no done: `alu_valid_o` = 1 with result 0 and the held trans_id, `timeout_o` = 1, go ABORT.
  - `mc_done_i` and timeout in the same cycle: done wins, no timeout.
- **ABORT** (exactly one cycle)
  - `fu_data_o` = hold register with operator forced to ADD and operands 0, so the bit-extension engine sees the op change and drops its state.
  - `alu_ready_o` = 0, `alu_valid_o` = 0. Any `mc_done_i` is ignored. Go IDLE.
- `mc_done_i` outside BUSY is ignored.
- Counter saturates; it never wraps.

## Timing
- Reset (async assert): state IDLE, counter 0, hold register 0.
- Reset value of every output:
  - `alu_valid_o` = 0, `timeout_o` = 0, `busy_o` = 0.
  - `alu_ready_o` = 1.
  - `alu_result_o` = 0, `alu_trans_id_o` = 0.
  - `fu_data_o` = `fu_data_i` (pass-through).
- Single-cycle op latency: 0 (combinational).
- Multi-cycle op:
  - Accepted at edge T, BUSY from T+1.
  - Writeback in the cycle `mc_done_i` is seen; the earliest is T+1.
  - Next issue can be accepted the cycle after the writeback.
- Timeout writeback occurs in the `MaxCycles`-th BUSY cycle, followed by one ABORT cycle.
- Flush: BUSY→ABORT→IDLE; ready returns 2 cycles after the flush edge.
- Reset mid-BUSY: immediate IDLE, no writeback.

## Structure
- `ariane_pkg` provides `fu_data_t`, `fu_op` (BEXT, BDEP, ADD) and `TRANS_ID_BITS`.
- Add `ALU_MC_MAX_CYCLES` = 72 to `ariane_pkg` as the default for `MaxCycles`.
- Add the state enum `alu_mc_state_e` to `ariane_pkg` so the scoreboard and assertions can reference it.
- Single module with no sub-modules. The `alu` is instantiated by the parent, alongside this block.

## Test plan
- ADD, a=5, b=7, trans_id=3, valid → same cycle: valid_o=1, result=12, id=3, ready stays 1.
- BEXT, a=0xF0F0, b=0xFF00, id=4; model pulses done after 10 cycles with result 0xF0 → ready low for 10 cycles and `fu_data_o` held stable; one writeback 0xF0/id=4; ready high the following cycle.
- BDEP issued, flush at BUSY cycle 3 → no writeback; one ABORT cycle with operator=ADD; ready=1 two cycles after the flush; a late `mc_done_i` is ignored.
- BEXT with done never asserted, `MaxCycles`=8 → at BUSY cycle 8: valid_o=1, result=0, timeout_o=1; then ABORT, then IDLE.
- Done and timeout in the same cycle, and done asserted together with flush → done wins over timeout (result written, no timeout); flush wins over done (no writeback).
- `rst_ni` asserted mid-BUSY → all outputs at reset values asynchronously; first issue after release is accepted normally.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared types for the issue path and the ALU multi-cycle controller.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS     = 3;
  // Default busy-cycle budget for BEXT/BDEP before the controller gives up.
  localparam int unsigned ALU_MC_MAX_CYCLES = 72;

  typedef enum logic [6:0] {
    ADD,
    SUB,
    XORL,
    ORL,
    ANDL,
    BEXT,
    BDEP
  } fu_op;

  typedef struct packed {
    fu_op                     operator;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [63:0]              imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef enum logic [1:0] {
    AluMcIdle,
    AluMcBusy,
    AluMcAbort
  } alu_mc_state_e;

  // Operators that run on the multi-cycle bit-manipulation engine.
  function automatic logic is_mc_op(fu_op op);
    return (op == BEXT) || (op == BDEP);
  endfunction

endpackage

// File: rtl/alu_mc_ctrl.sv
// Issue-side controller for the ALU multi-cycle path: passes single-cycle ops
// through, holds operands for BEXT/BDEP, and writes back one tagged result per op.
module alu_mc_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned MaxCycles = ALU_MC_MAX_CYCLES,
  parameter int unsigned CntWidth  = $clog2(MaxCycles + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  output fu_data_t                 fu_data_o,
  input  logic [63:0]              alu_result_i,
  input  logic                     mc_done_i,
  input  logic [63:0]              mc_result_i,
  output logic                     alu_valid_o,
  output logic [63:0]              alu_result_o,
  output logic [TRANS_ID_BITS-1:0] alu_trans_id_o,
  output logic                     timeout_o,
  output logic                     busy_o
);

  alu_mc_state_e       state_q, state_d;
  fu_data_t            hold_q, hold_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic issue_ok;
  logic mc_accept;
  logic timeout_hit;

  assign issue_ok    = alu_valid_i & ~flush_i;
  assign mc_accept   = issue_ok & is_mc_op(fu_data_i.operator);
  // Last allowed BUSY cycle: the MaxCycles-th cycle since entering BUSY.
  assign timeout_hit = (cnt_q == CntWidth'(MaxCycles - 1));

  // State, hold register and busy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= AluMcIdle;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, operand capture and saturating counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      AluMcIdle: begin
        if (mc_accept) begin
          hold_d  = fu_data_i;
          cnt_d   = '0;
          state_d = AluMcBusy;
        end
      end
      AluMcBusy: begin
        if (cnt_q != CntWidth'(MaxCycles)) cnt_d = cnt_q + CntWidth'(1);
        if (flush_i) begin
          state_d = AluMcAbort;
        end else if (mc_done_i) begin
          state_d = AluMcIdle;
        end else if (timeout_hit) begin
          state_d = AluMcAbort;
        end
      end
      AluMcAbort: begin
        state_d = AluMcIdle;
      end
      default: begin
        state_d = AluMcIdle;
      end
    endcase
  end

  // Issue handshake, ALU drive and writeback.
  always_comb begin
    alu_ready_o    = 1'b0;
    fu_data_o      = hold_q;
    alu_valid_o    = 1'b0;
    alu_result_o   = '0;
    alu_trans_id_o = '0;
    timeout_o      = 1'b0;
    busy_o         = (state_q != AluMcIdle);
    unique case (state_q)
      AluMcIdle: begin
        alu_ready_o = 1'b1;
        fu_data_o   = fu_data_i;
        if (issue_ok && !is_mc_op(fu_data_i.operator)) begin
          alu_valid_o    = 1'b1;
          alu_result_o   = alu_result_i;
          alu_trans_id_o = fu_data_i.trans_id;
        end
      end
      AluMcBusy: begin
        // Flush beats done, done beats timeout.
        if (!flush_i) begin
          if (mc_done_i) begin
            alu_valid_o    = 1'b1;
            alu_result_o   = mc_result_i;
            alu_trans_id_o = hold_q.trans_id;
          end else if (timeout_hit) begin
            alu_valid_o    = 1'b1;
            alu_trans_id_o = hold_q.trans_id;
            timeout_o      = 1'b1;
          end
        end
      end
      AluMcAbort: begin
        // Changing the op lets the bit-extension engine drop its internal state.
        fu_data_o.operator  = ADD;
        fu_data_o.operand_a = '0;
        fu_data_o.operand_b = '0;
        fu_data_o.imm       = '0;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mc_ctrl.sv
// Directed self-checking bench for alu_mc_ctrl; a second instance with a short
// cycle budget covers the timeout paths.
module tb_alu_mc_ctrl;
  import ariane_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  fu_data_t                 fu_i;
  logic                     valid_a, valid_b;
  logic [63:0]              alu_res;
  logic                     mc_done;
  logic [63:0]              mc_res;

  logic                     rdy_a, v_a, to_a, busy_a;
  fu_data_t                 fuo_a;
  logic [63:0]              res_a;
  logic [TRANS_ID_BITS-1:0] id_a;

  logic                     rdy_b, v_b, to_b, busy_b;
  fu_data_t                 fuo_b;
  logic [63:0]              res_b;
  logic [TRANS_ID_BITS-1:0] id_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .fu_data_i      (fu_i),
    .alu_valid_i    (valid_a),
    .alu_ready_o    (rdy_a),
    .fu_data_o      (fuo_a),
    .alu_result_i   (alu_res),
    .mc_done_i      (mc_done),
    .mc_result_i    (mc_res),
    .alu_valid_o    (v_a),
    .alu_result_o   (res_a),
    .alu_trans_id_o (id_a),
    .timeout_o      (to_a),
    .busy_o         (busy_a)
  );

  alu_mc_ctrl #(.MaxCycles(8)) dut8 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .fu_data_i      (fu_i),
    .alu_valid_i    (valid_b),
    .alu_ready_o    (rdy_b),
    .fu_data_o      (fuo_b),
    .alu_result_i   (alu_res),
    .mc_done_i      (mc_done),
    .mc_result_i    (mc_res),
    .alu_valid_o    (v_b),
    .alu_result_o   (res_b),
    .alu_trans_id_o (id_b),
    .timeout_o      (to_b),
    .busy_o         (busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TRANS_ID_BITS-1:0] id);
    fu_i.operator  = op;
    fu_i.operand_a = a;
    fu_i.operand_b = b;
    fu_i.imm       = 64'h0;
    fu_i.trans_id  = id;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    mc_done = 1'b0;
    mc_res  = 64'h0;
    alu_res = 64'h0;
    set_op(ADD, 64'h11, 64'h22, 3'd5);

    // Reset values
    #3;
    check("rst_valid", 64'(v_a), 64'd0);
    check("rst_ready", 64'(rdy_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_timeout", 64'(to_a), 64'd0);
    check("rst_result", res_a, 64'd0);
    check("rst_id", 64'(id_a), 64'd0);
    check("rst_pass_a", fuo_a.operand_a, 64'h11);
    check("rst_pass_id", 64'(fuo_a.trans_id), 64'd5);
    #9 rst_n = 1'b1;
    tick();

    // Single-cycle ADD, zero latency
    set_op(ADD, 64'd5, 64'd7, 3'd3);
    alu_res = 64'd12;
    valid_a = 1'b1;
    @(negedge clk);
    check("add_valid", 64'(v_a), 64'd1);
    check("add_result", res_a, 64'd12);
    check("add_id", 64'(id_a), 64'd3);
    check("add_ready", 64'(rdy_a), 64'd1);
    check("add_pass_b", fuo_a.operand_b, 64'd7);
    tick();
    check("add_stay_idle", 64'(busy_a), 64'd0);

    // BEXT with completion after 10 BUSY cycles
    set_op(BEXT, 64'hF0F0, 64'hFF00, 3'd4);
    alu_res = 64'hDEAD;
    @(negedge clk);
    check("bext_issue_valid", 64'(v_a), 64'd0);
    check("bext_issue_ready", 64'(rdy_a), 64'd1);
    tick();
    valid_a = 1'b0;
    set_op(SUB, 64'h1234, 64'h5678, 3'd1);
    for (int i = 1; i <= 10; i++) begin
      mc_done = (i == 10);
      mc_res  = (i == 10) ? 64'hF0 : 64'h77;
      @(negedge clk);
      check("bext_ready", 64'(rdy_a), 64'd0);
      check("bext_busy", 64'(busy_a), 64'd1);
      check("bext_hold_a", fuo_a.operand_a, 64'hF0F0);
      check("bext_hold_b", fuo_a.operand_b, 64'hFF00);
      check("bext_hold_op", 64'(fuo_a.operator), 64'(BEXT));
      check("bext_wb_valid", 64'(v_a), (i == 10) ? 64'd1 : 64'd0);
      if (i == 10) begin
        check("bext_wb_result", res_a, 64'hF0);
        check("bext_wb_id", 64'(id_a), 64'd4);
        check("bext_no_timeout", 64'(to_a), 64'd0);
      end
      tick();
    end
    mc_done = 1'b0;
    @(negedge clk);
    check("bext_ready_after", 64'(rdy_a), 64'd1);
    check("bext_idle_after", 64'(busy_a), 64'd0);
    check("bext_no_second_wb", 64'(v_a), 64'd0);
    tick();

    // BDEP flushed in BUSY cycle 3, then late done pulses
    set_op(BDEP, 64'hAA, 64'h55, 3'd2);
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_no_wb", 64'(v_a), 64'd0);
    tick();
    flush   = 1'b0;
    mc_done = 1'b1;
    mc_res  = 64'h99;
    @(negedge clk);
    check("abort_op", 64'(fuo_a.operator), 64'(ADD));
    check("abort_a", fuo_a.operand_a, 64'd0);
    check("abort_b", fuo_a.operand_b, 64'd0);
    check("abort_ready", 64'(rdy_a), 64'd0);
    check("abort_valid", 64'(v_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd1);
    tick();
    @(negedge clk);
    check("flush_ready_back", 64'(rdy_a), 64'd1);
    check("late_done_ignored", 64'(v_a), 64'd0);
    tick();
    mc_done = 1'b0;
    @(negedge clk);
    check("late_done_idle", 64'(busy_a), 64'd0);
    tick();

    // Timeout with an 8-cycle budget
    set_op(BEXT, 64'h3, 64'h1, 3'd6);
    alu_res = 64'hBEEF;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("to_valid", 64'(v_b), (i == 8) ? 64'd1 : 64'd0);
      check("to_pulse", 64'(to_b), (i == 8) ? 64'd1 : 64'd0);
      if (i == 8) begin
        check("to_result", res_b, 64'd0);
        check("to_id", 64'(id_b), 64'd6);
      end
      tick();
    end
    @(negedge clk);
    check("to_abort_busy", 64'(busy_b), 64'd1);
    check("to_abort_ready", 64'(rdy_b), 64'd0);
    check("to_abort_op", 64'(fuo_b.operator), 64'(ADD));
    check("to_abort_pulse", 64'(to_b), 64'd0);
    tick();
    @(negedge clk);
    check("to_idle_ready", 64'(rdy_b), 64'd1);
    tick();

    // Done coincides with timeout: done wins
    set_op(BDEP, 64'h8, 64'h9, 3'd7);
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    mc_done = 1'b1;
    mc_res  = 64'hABCD;
    @(negedge clk);
    check("dt_valid", 64'(v_b), 64'd1);
    check("dt_result", res_b, 64'hABCD);
    check("dt_no_timeout", 64'(to_b), 64'd0);
    tick();
    mc_done = 1'b0;
    @(negedge clk);
    check("dt_ready_next", 64'(rdy_b), 64'd1);
    tick();

    // Done coincides with flush: flush wins
    set_op(BEXT, 64'h4, 64'h4, 3'd1);
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    mc_done = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    check("fd_no_wb", 64'(v_a), 64'd0);
    tick();
    mc_done = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    check("fd_abort_ready", 64'(rdy_a), 64'd0);
    tick();
    @(negedge clk);
    check("fd_idle_ready", 64'(rdy_a), 64'd1);
    tick();

    // Asynchronous reset in the middle of BUSY
    set_op(BEXT, 64'h5, 64'h6, 3'd2);
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    set_op(ORL, 64'h42, 64'h0, 3'd3);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy_a), 64'd0);
    check("mrst_ready", 64'(rdy_a), 64'd1);
    check("mrst_valid", 64'(v_a), 64'd0);
    check("mrst_result", res_a, 64'd0);
    check("mrst_id", 64'(id_a), 64'd0);
    check("mrst_pass_a", fuo_a.operand_a, 64'h42);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_op(ADD, 64'd1, 64'd2, 3'd1);
    alu_res = 64'd3;
    valid_a = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(v_a), 64'd1);
    check("post_rst_result", res_a, 64'd3);
    check("post_rst_id", 64'(id_a), 64'd1);
    tick();
    set_op(BDEP, 64'h1, 64'h1, 3'd4);
    tick();
    valid_a = 1'b0;
    @(negedge clk);
    check("post_rst_mc_busy", 64'(busy_a), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
